// File: rtl/dm_pkg.sv
// Shared data-memory definitions: Funct3 encodings plus byte-enable, store-replicate,
// alignment and load-extend helpers, reusable by the forwarding unit.
package dm_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } f3_e;

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = 4'b0011 << off;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] sd;
        case (f3)
            F3_B:    sd = {4{wd[7:0]}};
            F3_H:    sd = {2{wd[15:0]}};
            default: sd = wd;
        endcase
        return sd;
    endfunction

    // LHU is only a load encoding, so it never flags a store.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off,
                                        input logic is_store);
        logic m;
        case (f3)
            F3_H:    m = off[0];
            F3_HU:   m = ~is_store & off[0];
            F3_W:    m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
        logic [1:0] o;
        case (f3)
            F3_H, F3_HU: o = {off[1], 1'b0};
            F3_W:        o = 2'b00;
            default:     o = off;
        endcase
        return o;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    res = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   res = {24'h000000, sh[7:0]};
            F3_H:    res = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   res = {16'h0000, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Four-lane byte-enabled synchronous RAM, read-first, registered read data.
module dm_byte_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [DEPTH];

    // Lane writes and read-first registered read; read data holds when re is low.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][i] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable MEM-stage data memory with extended one-cycle loads.
// Optional misalignment trapping is enabled by defining DM_MISALIGN_TRAP_EN.
module data_mem_ctrl
    import dm_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic [DATA_W-1:0]     rd,
    output logic                  rd_valid,
    output logic                  misalign
);

    localparam int DEPTH = 2 ** (DM_ADDRESS - 2);
`ifdef DM_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    if (DATA_W != 32) begin : g_width_check
        $error("data_mem_ctrl supports DATA_W == 32 only");
    end

    logic [1:0]  off;
    logic        mis;
    logic [1:0]  eff_off;
    logic        blocked;
    logic        wr_go;
    logic        rd_go;
    logic [3:0]  be;
    logic [31:0] ram_q;

    logic        valid_r;
    logic        have_r;
    logic        mis_r;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;

    assign off = a[1:0];

    // Request decode; a simultaneous write wins, so its store rules define misalignment.
    always_comb begin
        mis = 1'b0;
        if (MemWrite) begin
            mis = misaligned(Funct3, off, 1'b1);
        end else if (MemRead) begin
            mis = misaligned(Funct3, off, 1'b0);
        end else begin
            mis = 1'b0;
        end
        eff_off = TRAP_EN ? off : align_off(Funct3, off);
        blocked = TRAP_EN & mis;
        wr_go   = MemWrite & ~reset & ~blocked;
        rd_go   = MemRead & ~MemWrite & ~reset & ~blocked;
        be      = wr_go ? byte_en(Funct3, eff_off) : 4'b0000;
    end

    dm_byte_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (be),
        .re    (rd_go),
        .addr  (a[DM_ADDRESS-1:2]),
        .wdata (store_data(Funct3, wd)),
        .rdata (ram_q)
    );

    // Request pipeline: lane select and extension follow the RAM's registered word.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            have_r  <= 1'b0;
            mis_r   <= 1'b0;
            f3_r    <= 3'b000;
            off_r   <= 2'b00;
        end else begin
            valid_r <= rd_go;
            mis_r   <= TRAP_EN & mis;
            if (rd_go) begin
                have_r <= 1'b1;
                f3_r   <= Funct3;
                off_r  <= eff_off;
            end
        end
    end

    // f3_r/off_r and the RAM word only change on accepted loads, so rd holds otherwise.
    assign rd       = have_r ? load_ext(f3_r, off_r, ram_q) : {DATA_W{1'b0}};
    assign rd_valid = valid_r;
    assign misalign = mis_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus random traffic
// against a byte-array reference model.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [2:0]  Funct3;
    logic [31:0] rd;
    logic        rd_valid;
    logic        misalign;

    logic [7:0]  mem_m [512];
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic        exp_mis;
    int          errors = 0;
    int          checks = 0;

    data_mem_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .a        (a),
        .wd       (wd),
        .Funct3   (Funct3),
        .rd       (rd),
        .rd_valid (rd_valid),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input int v, input int bits);
        int r;
        r = v;
        if (r >= (1 << (bits - 1))) r = r - (1 << bits);
        return 32'(r);
    endfunction

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input int base, input int off);
        int b0;
        int h0;
        b0 = int'(mem_m[base + off]);
        h0 = (off <= 2) ? int'(mem_m[base + off]) + 256 * int'(mem_m[base + off + 1]) : 0;
        case (f3)
            3'd0:    return sext(b0, 8);
            3'd4:    return 32'(b0);
            3'd1:    return sext(h0, 16);
            3'd5:    return 32'(h0);
            default: return {mem_m[base + 3], mem_m[base + 2], mem_m[base + 1], mem_m[base]};
        endcase
    endfunction

    task automatic step(input string tag, input logic r, input logic mr, input logic mw,
                        input logic [8:0] ad, input logic [31:0] d, input logic [2:0] f3);
        int  off;
        int  base;
        bit  mis;
        bit  blk;
        off  = int'(ad) % 4;
        base = int'(ad) - off;
        mis  = 1'b0;
        if (mw)      mis = (f3 == 3'd1 && off % 2 == 1) || (f3 == 3'd2 && off != 0);
        else if (mr) mis = ((f3 == 3'd1 || f3 == 3'd5) && off % 2 == 1) || (f3 == 3'd2 && off != 0);
`ifdef DM_MISALIGN_TRAP_EN
        blk = mis;
`else
        blk = 1'b0;
        mis = 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) off = off - off % 2;
        if (f3 == 3'd2) off = 0;
`endif
        reset = r; MemRead = mr; MemWrite = mw; a = ad; wd = d; Funct3 = f3;
        if (r) begin
            exp_valid = 1'b0; exp_rd = 32'h0; exp_mis = 1'b0;
        end else begin
            exp_mis = mis;
            if (mw && !blk) begin
                if (f3 == 3'd0) mem_m[base + off] = d[7:0];
                if (f3 == 3'd1) begin
                    mem_m[base + off] = d[7:0]; mem_m[base + off + 1] = d[15:8];
                end
                if (f3 == 3'd2) begin
                    for (int i = 0; i < 4; i++) mem_m[base + i] = d[8*i +: 8];
                end
            end
            exp_valid = mr && !mw && !blk;
            if (exp_valid) exp_rd = ld_model(f3, base, off);
        end
        @(posedge clk);
        #1;
        check_eq({tag, ".rd_valid"}, {31'h0, rd_valid}, {31'h0, exp_valid});
        check_eq({tag, ".misalign"}, {31'h0, misalign}, {31'h0, exp_mis});
        check_eq({tag, ".rd"}, rd, exp_rd);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 3'd0);
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; a = 9'h0; wd = 32'h0; Funct3 = 3'd0;
        exp_rd = 32'h0; exp_valid = 1'b0; exp_mis = 1'b0;
        for (int i = 0; i < 512; i++) mem_m[i] = 8'h00;
        @(negedge clk);
        step("reset0", 1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 3'd0);
        step("reset1", 1'b1, 1'b1, 1'b1, 9'h010, 32'hFFFF_FFFF, 3'd2);

        for (int w = 0; w < 128; w++) begin
            step("clear", 1'b0, 1'b0, 1'b1, 9'(w * 4), 32'h0, 3'd2);
        end

        step("sw_010", 1'b0, 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'd2);
        step("lw_010", 1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
        check_eq("tp_lw_deadbeef", rd, 32'hDEADBEEF);
        idle("pulse_end");

        step("sb_013", 1'b0, 1'b0, 1'b1, 9'h013, 32'h0000_0080, 3'd0);
        step("lb_013", 1'b0, 1'b1, 1'b0, 9'h013, 32'h0, 3'd0);
        check_eq("tp_lb", rd, 32'hFFFFFF80);
        step("lbu_013", 1'b0, 1'b1, 1'b0, 9'h013, 32'h0, 3'd4);
        check_eq("tp_lbu", rd, 32'h00000080);
        step("lw_010b", 1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
        check_eq("tp_lw_merged", rd, 32'h80ADBEEF);
        idle("hold");
        check_eq("tp_rd_hold", rd, 32'h80ADBEEF);

        step("sh_022", 1'b0, 1'b0, 1'b1, 9'h022, 32'h0000_1234, 3'd1);
        step("lhu_022", 1'b0, 1'b1, 1'b0, 9'h022, 32'h0, 3'd5);
        check_eq("tp_lhu", rd, 32'h00001234);
        step("sh_020", 1'b0, 1'b0, 1'b1, 9'h020, 32'h0000_8001, 3'd1);
        step("lh_020", 1'b0, 1'b1, 1'b0, 9'h020, 32'h0, 3'd1);
        check_eq("tp_lh", rd, 32'hFFFF8001);

        step("b2b_0", 1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
        step("b2b_1", 1'b0, 1'b1, 1'b0, 9'h020, 32'h0, 3'd2);
        step("b2b_2", 1'b0, 1'b1, 1'b0, 9'h012, 32'h0, 3'd5);
        step("rw_both", 1'b0, 1'b1, 1'b1, 9'h040, 32'hCAFE_F00D, 3'd2);
        step("rw_check", 1'b0, 1'b1, 1'b0, 9'h040, 32'h0, 3'd2);
        check_eq("tp_rw_written", rd, 32'hCAFEF00D);

        step("sw_031", 1'b0, 1'b0, 1'b1, 9'h031, 32'h1122_3344, 3'd2);
        step("lw_030", 1'b0, 1'b1, 1'b0, 9'h030, 32'h0, 3'd2);
`ifdef DM_MISALIGN_TRAP_EN
        check_eq("tp_misalign_nowrite", rd, 32'h00000000);
`else
        check_eq("tp_misalign_aligned", rd, 32'h11223344);
`endif

        step("ld_pre_rst", 1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
        step("rst_after_ld", 1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 3'd0);
        check_eq("tp_rst_rd", rd, 32'h0);
        step("ld_post_rst", 1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
        check_eq("tp_post_rst", rd, 32'h80ADBEEF);

        for (int n = 0; n < 600; n++) begin
            logic       r;
            logic       mr;
            logic       mw;
            logic [8:0] ad;
            r  = ($urandom_range(0, 39) == 0);
            mr = ($urandom_range(0, 2) != 0);
            mw = ($urandom_range(0, 2) == 0);
            ad = 9'($urandom_range(0, 511));
            step("rand", r, mr, mw, ad, $urandom, 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
